// File: rtl/rdi_pkg.sv
// Shared RDI definitions: link state encodings, sequencer FSM states, default timeout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rdi_pkg;

  // 4-bit RDI state encodings carried on lp_state_req / pl_state_sts.
  typedef enum logic [3:0] {
    RDI_NOP       = 4'b0000,
    RDI_ACTIVE    = 4'b0001,
    RDI_L1        = 4'b0100,
    RDI_L2        = 4'b1000,
    RDI_LINKRESET = 4'b1001,
    RDI_LINKERROR = 4'b1010,
    RDI_RETRAIN   = 4'b1011,
    RDI_DISABLED  = 4'b1100
  } rdi_state_e;

  // Sequencer FSM states; explicit values keep the encoding stable for debug taps.
  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_WAKE     = 3'd1,
    SEQ_WAIT_ACK = 3'd2,
    SEQ_WAIT_STS = 3'd3,
    SEQ_RELEASE  = 3'd4,
    SEQ_ABORT    = 3'd5
  } seq_state_e;

  localparam int unsigned RDI_TIMEOUT_CYCLES_DEFAULT = 1024;

  // True for the eight encodings an adapter may legally request.
  function automatic logic rdi_state_legal(input logic [3:0] enc);
    logic ok;
    ok = 1'b0;
    case (enc)
      RDI_NOP, RDI_ACTIVE, RDI_L1, RDI_L2,
      RDI_LINKRESET, RDI_LINKERROR, RDI_RETRAIN, RDI_DISABLED: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rdi_timeout_cnt.sv
// Wait-state watchdog: counts enabled cycles and flags the terminal cycle.
// Latency: expire asserts in the cycle the count reaches TERMINAL-1 (count starts at 0 after clear).
// Backpressure: none; clear has priority over enable, count saturates at TERMINAL-1.
module rdi_timeout_cnt
  import rdi_pkg::*;
#(
  parameter int unsigned TERMINAL = RDI_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

  logic [CW-1:0] cnt;

  // Cycle counter; holds at the terminal value so it can never wrap back to zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_expire = i_en && (cnt == LAST);

endmodule

// File: rtl/rdi_lp_state_sequencer.sv
// Drives the RDI lp_wake_req / lp_state_req handshake to move the link to an adapter-requested state.
// Latency: rejects/no-op completions one cycle after accept; otherwise wake -> ack -> status -> ack release.
// Backpressure: o_cmd_ready is high only while idle; valid outside idle is ignored. All outputs registered.
module rdi_lp_state_sequencer
  import rdi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = RDI_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [3:0] i_cmd_state,
  output logic       o_cmd_ready,
  output logic       o_cmd_done,
  output logic       o_cmd_err,
  output logic       o_lp_wake_req,
  input  logic       i_pl_wake_ack,
  output logic [3:0] o_lp_state_req,
  input  logic [3:0] i_pl_state_sts,
  input  logic       i_pl_clk_req,
  output logic       o_lp_clk_ack
);

  seq_state_e state_q;
  seq_state_e state_d;
  logic [3:0] target_q;

  logic       accept;
  logic       cmd_legal;
  logic       cmd_noop;
  logic       sts_match;
  logic       link_err;
  logic       tmo_clr;
  logic       tmo_en;
  logic       tmo_expire;

  logic       done_d;
  logic       err_d;
  logic       wake_d;
  logic [3:0] sreq_d;

  assign accept    = i_cmd_valid && o_cmd_ready && (state_q == SEQ_IDLE);
  assign cmd_legal = rdi_state_legal(i_cmd_state);
  assign cmd_noop  = (i_cmd_state == i_pl_state_sts);
  assign sts_match = (i_pl_state_sts == target_q);
  // A link error only aborts if the adapter was not deliberately heading there.
  assign link_err  = (i_pl_state_sts == RDI_LINKERROR) && (target_q != RDI_LINKERROR);

  // Counter restarts on every state change, so each wait state gets its own full budget.
  assign tmo_clr = (state_d != state_q);
  assign tmo_en  = (state_q == SEQ_WAIT_ACK) || (state_q == SEQ_WAIT_STS);

  rdi_timeout_cnt #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (tmo_clr),
    .i_en     (tmo_en),
    .o_expire (tmo_expire)
  );

  // Next state and next output values; progress beats timeout, link error beats ack.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sreq_d  = o_lp_state_req;
    case (state_q)
      SEQ_IDLE: begin
        if (accept) begin
          if (!cmd_legal) begin
            err_d = 1'b1;
          end else if (cmd_noop) begin
            done_d = 1'b1;
          end else begin
            state_d = SEQ_WAKE;
          end
        end
      end
      SEQ_WAKE: begin
        state_d = SEQ_WAIT_ACK;
      end
      SEQ_WAIT_ACK: begin
        if (link_err) begin
          state_d = SEQ_ABORT;
        end else if (i_pl_wake_ack) begin
          state_d = SEQ_WAIT_STS;
          sreq_d  = target_q;
        end else if (tmo_expire) begin
          state_d = SEQ_ABORT;
        end
      end
      SEQ_WAIT_STS: begin
        if (sts_match) begin
          state_d = SEQ_RELEASE;
        end else if (link_err || tmo_expire) begin
          state_d = SEQ_ABORT;
        end
      end
      SEQ_RELEASE: begin
        if (!i_pl_wake_ack) begin
          state_d = SEQ_IDLE;
          done_d  = 1'b1;
        end
      end
      SEQ_ABORT: begin
        if (!i_pl_wake_ack) begin
          state_d = SEQ_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    if ((state_d == SEQ_ABORT) && (state_q != SEQ_ABORT)) begin
      sreq_d = RDI_NOP;
    end
    wake_d = (state_d == SEQ_WAKE) || (state_d == SEQ_WAIT_ACK) || (state_d == SEQ_WAIT_STS);
  end

  // FSM, latched target and all handshake outputs, registered together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= SEQ_IDLE;
      target_q       <= 4'b0000;
      o_cmd_ready    <= 1'b0;
      o_cmd_done     <= 1'b0;
      o_cmd_err      <= 1'b0;
      o_lp_wake_req  <= 1'b0;
      o_lp_state_req <= 4'b0000;
    end else begin
      state_q        <= state_d;
      o_cmd_ready    <= (state_d == SEQ_IDLE);
      o_cmd_done     <= done_d;
      o_cmd_err      <= err_d;
      o_lp_wake_req  <= wake_d;
      o_lp_state_req <= sreq_d;
      if (accept) begin
        target_q <= i_cmd_state;
      end
    end
  end

  // Clock request acknowledge is a plain one-cycle echo, unrelated to the FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_lp_clk_ack <= 1'b0;
    end else begin
      o_lp_clk_ack <= i_pl_clk_req;
    end
  end

  a_done_err_excl: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_cmd_done && o_cmd_err));
  a_ready_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    o_cmd_ready |-> (state_q == SEQ_IDLE));

endmodule

// File: tb/tb_rdi_lp_state_sequencer.sv
// Scoreboard bench for the RDI low-power state sequencer with a randomized physical-layer responder.
// Latency: responses are matched in order whenever done/err pulses.
// Backpressure: commands are issued only when ready is seen high.
module tb_rdi_lp_state_sequencer;

  localparam int T = 16;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_cmd_valid;
  logic [3:0] i_cmd_state;
  logic       o_cmd_ready;
  logic       o_cmd_done;
  logic       o_cmd_err;
  logic       o_lp_wake_req;
  logic       i_pl_wake_ack;
  logic [3:0] o_lp_state_req;
  logic [3:0] i_pl_state_sts;
  logic       i_pl_clk_req;
  logic       o_lp_clk_ack;

  rdi_lp_state_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd_state    (i_cmd_state),
    .o_cmd_ready    (o_cmd_ready),
    .o_cmd_done     (o_cmd_done),
    .o_cmd_err      (o_cmd_err),
    .o_lp_wake_req  (o_lp_wake_req),
    .i_pl_wake_ack  (i_pl_wake_ack),
    .o_lp_state_req (o_lp_state_req),
    .i_pl_state_sts (i_pl_state_sts),
    .i_pl_clk_req   (i_pl_clk_req),
    .o_lp_clk_ack   (o_lp_clk_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       err;
    logic [3:0] req;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] exp_req;
  int         total = 0;
  int         bad = 0;
  logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] v);
    bit ok = 0;
    foreach (codes[i]) if (codes[i] == v) ok = 1;
    return ok;
  endfunction

  // Outcome of one command from the protocol rules: j = PHY cycles from wake to ack,
  // s = cycles in status wait before target status appears, le = link error injected.
  function automatic exp_t model(input logic [3:0] tgt, input logic [3:0] cur,
                                 input int j, input int s, input bit le, output bit imm);
    exp_t e;
    imm = 0;
    if (!legal(tgt)) begin
      imm = 1; e.err = 1; e.req = exp_req;
    end else if (tgt == cur) begin
      imm = 1; e.err = 0; e.req = exp_req;
    end else if ((cur == 4'hA && tgt != 4'hA) || le || j > T || s > T - 1) begin
      e.err = 1; e.req = 4'h0;
    end else begin
      e.err = 0; e.req = tgt;
    end
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!o_cmd_ready && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_cmd_ready) chk("ready_bound", o_cmd_ready, 1);
  endtask

  // Garbage commands while busy must be ignored.
  task automatic noise();
    i_cmd_valid = 1'($urandom_range(0, 1));
    i_cmd_state = 4'($urandom_range(0, 15));
  endtask

  task automatic run_cmd(input logic [3:0] tgt, input int j, input int s,
                         input bit le, input int le_at, input int r);
    exp_t e;
    bit   imm;
    bit   acked;
    bit   dropped;
    wait_ready();
    e = model(tgt, i_pl_state_sts, j, s, le, imm);
    sb.push_back(e);
    exp_req = e.req;
    i_cmd_valid = 1; i_cmd_state = tgt;
    @(posedge i_clk); #1;
    i_cmd_valid = 0;
    if (imm) begin
      chk("imm_no_wake", o_lp_wake_req, 0);
      chk("imm_err", o_cmd_err, e.err);
      chk("imm_done", o_cmd_done, !e.err);
      @(posedge i_clk); #1;
      chk("imm_no_wake2", o_lp_wake_req, 0);
      return;
    end
    chk("wake_rise", o_lp_wake_req, 1);
    acked = 0; dropped = 0;
    for (int i = 1; i <= T + 8 && !dropped && !acked; i++) begin
      @(posedge i_clk); #1;
      if (!o_lp_wake_req) begin
        dropped = 1; i_cmd_valid = 0;
      end else begin
        noise();
        if (i == j) begin i_pl_wake_ack = 1; acked = 1; end
      end
    end
    if (acked) begin
      for (int k = 0; k <= T + 8 && !dropped; k++) begin
        @(posedge i_clk); #1;
        if (!o_lp_wake_req) begin
          dropped = 1; i_cmd_valid = 0;
        end else begin
          noise();
          if (k == 0) chk("sreq_drive", o_lp_state_req, tgt);
          if (le && k == le_at) i_pl_state_sts = 4'hA;
          else if (!le && k == s) i_pl_state_sts = tgt;
        end
      end
    end
    i_cmd_valid = 0;
    if (!dropped) chk("wake_drop_bound", o_lp_wake_req, 0);
    repeat (r) begin @(posedge i_clk); #1; end
    i_pl_wake_ack = 0;
    if (e.err && i_pl_state_sts == 4'hA) i_pl_state_sts = 4'h0;
  endtask

  // Scoreboard monitor: every done/err pulse consumes one expected response.
  always @(negedge i_clk) begin
    if (!i_rst && (o_cmd_done || o_cmd_err)) begin
      chk("done_err_excl", o_cmd_done & o_cmd_err, 0);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b with no command pending at %0t",
                 o_cmd_done, o_cmd_err, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_err", o_cmd_err, mon_e.err);
        chk("resp_sreq", o_lp_state_req, mon_e.req);
      end
    end
  end

  // Clock request echo check: ack at each falling edge equals request one cycle earlier.
  logic prev_req;
  bit   prev_ok = 0;
  always @(negedge i_clk) begin
    if (i_rst) prev_ok <= 0;
    else begin
      if (prev_ok) chk("clk_ack", o_lp_clk_ack, prev_req);
      prev_ok <= 1;
    end
    prev_req <= i_pl_clk_req;
  end

  initial begin
    i_pl_clk_req = 0;
    forever begin
      @(posedge i_clk); #1;
      i_pl_clk_req = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tgt;
    int j, s, le_at, r;
    bit le;
    i_rst = 1; i_cmd_valid = 0; i_cmd_state = 0;
    i_pl_wake_ack = 0; i_pl_state_sts = 0; exp_req = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_done", o_cmd_done, 0);
    chk("rst_err", o_cmd_err, 0);
    chk("rst_wake", o_lp_wake_req, 0);
    chk("rst_sreq", o_lp_state_req, 0);
    chk("rst_clk_ack", o_lp_clk_ack, 0);
    i_rst = 0;
    @(posedge i_clk); #1;
    chk("ready_after_rst", o_cmd_ready, 1);

    run_cmd(4'h1, 3, 5, 0, 0, 2);          // ACTIVE from RESET, full handshake
    run_cmd(4'h7, 1, 0, 0, 0, 0);          // illegal encoding
    run_cmd(4'h4, T + 5, 0, 0, 0, 0);      // never acked: timeout in WAIT_ACK
    run_cmd(4'h4, 2, 9, 1, 2, 1);          // link error while waiting for L1
    i_pl_state_sts = 4'h1;
    run_cmd(4'h1, 1, 0, 0, 0, 0);          // already there
    run_cmd(4'h8, T, T - 1, 0, 0, 1);      // both waits at the last allowed cycle
    run_cmd(4'h1, T + 1, 0, 0, 0, 0);      // ack one cycle too late
    run_cmd(4'h4, 1, T, 0, 0, 3);          // status one cycle too late
    run_cmd(4'hA, 2, 1, 0, 0, 0);          // deliberately to LINKERROR
    run_cmd(4'h1, 1, 0, 0, 0, 0);          // from LINKERROR: aborts at once

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 7) tgt = codes[$urandom_range(0, 7)];
      else tgt = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: j = T;
        1: j = T + 1;
        2: j = T + 5;
        default: j = $urandom_range(1, 6);
      endcase
      case ($urandom_range(0, 5))
        0: s = T - 1;
        1: s = T;
        2: s = 0;
        default: s = $urandom_range(0, 6);
      endcase
      le = ($urandom_range(0, 5) == 0) && (tgt != 4'hA);
      le_at = $urandom_range(0, 5);
      r = $urandom_range(0, 3);
      run_cmd(tgt, j, s, le, le_at, r);
    end

    // Reset while waiting for status: request outputs clear without a clock edge.
    wait_ready();
    i_pl_state_sts = 4'h0;
    i_cmd_valid = 1; i_cmd_state = 4'h4;
    @(posedge i_clk); #1;
    i_cmd_valid = 0;
    chk("mid_wake_rise", o_lp_wake_req, 1);
    @(posedge i_clk); #1;
    i_pl_wake_ack = 1;
    @(posedge i_clk); #1;
    chk("mid_sreq", o_lp_state_req, 4'h4);
    @(posedge i_clk); #1;
    i_rst = 1;
    #1;
    chk("mid_rst_wake", o_lp_wake_req, 0);
    chk("mid_rst_sreq", o_lp_state_req, 0);
    chk("mid_rst_ready", o_cmd_ready, 0);
    i_pl_wake_ack = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0; exp_req = 0;
    @(posedge i_clk); #1;
    chk("mid_ready_after", o_cmd_ready, 1);

    run_cmd(4'h1, 2, 2, 0, 0, 1);          // normal operation resumes after reset

    repeat (6) @(posedge i_clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rdi_lp_state_sequencer.md
RDI_LP_STATE_SEQUENCER -- requirements
Module: rdi_lp_state_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles spent in any wait state before abort.
REQ-002 i_clk  in  1  RDI clock; all logic on its rising edge; single clock domain.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_cmd_valid  in  1  adapter request to move link to i_cmd_state.
REQ-005 i_cmd_state  in  4  target RDI state encoding.
REQ-006 o_cmd_ready  out  1  high only in IDLE; command accepted when valid&ready.
REQ-007 o_cmd_done  out  1  one-cycle pulse, command completed.
REQ-008 o_cmd_err  out  1  one-cycle pulse, command rejected or aborted.
REQ-009 o_lp_wake_req  out  1  RDI lp_wake_req to physical layer.
REQ-010 i_pl_wake_ack  in  1  RDI pl_wake_ack.
REQ-011 o_lp_state_req  out  4  RDI lp_state_req.
REQ-012 i_pl_state_sts  in  4  RDI pl_state_sts.
REQ-013 i_pl_clk_req  in  1  RDI pl_clk_req; o_lp_clk_ack  out  1  RDI lp_clk_ack.

Function
REQ-014 Encodings: NOP/RESET 0000, ACTIVE 0001, L1 0100, L2 1000, LINKRESET 1001, LINKERROR 1010, RETRAIN 1011, DISABLED 1100; any other value is invalid.
REQ-015 FSM states: IDLE, WAKE, WAIT_ACK, WAIT_STS, RELEASE, ABORT.
REQ-016 IDLE: on accept, target latched; next cycle state WAKE with o_lp_wake_req=1.
REQ-017 Invalid target on accept: no wake, o_cmd_err pulses the cycle after accept, FSM stays IDLE.
REQ-018 Target equal to i_pl_state_sts at accept: no wake, o_cmd_done pulses the cycle after accept, FSM stays IDLE.
REQ-019 WAKE -> WAIT_ACK unconditionally after one cycle; o_lp_wake_req held high through WAIT_STS.
REQ-020 WAIT_ACK: on i_pl_wake_ack=1, o_lp_state_req driven to target from next cycle, FSM -> WAIT_STS.
REQ-021 WAIT_STS: on i_pl_state_sts==target, o_lp_wake_req drops next cycle, FSM -> RELEASE.
REQ-022 RELEASE: on i_pl_wake_ack=0, o_cmd_done pulses next cycle, FSM -> IDLE; o_lp_state_req keeps target.
REQ-023 Timeout counter clears on entry to WAIT_ACK and WAIT_STS, increments each cycle there; reaching TIMEOUT_CYCLES-1 -> ABORT.
REQ-024 i_pl_state_sts==LINKERROR in WAIT_ACK or WAIT_STS with target not LINKERROR -> ABORT same as timeout.
REQ-025 ABORT: o_lp_wake_req=0, o_lp_state_req=NOP; on i_pl_wake_ack=0, o_cmd_err pulses, FSM -> IDLE.
REQ-026 Timeout and status match in same cycle: match wins.
REQ-027 o_cmd_done and o_cmd_err never high together; i_cmd_valid ignored outside IDLE.
REQ-028 o_lp_clk_ack follows i_pl_clk_req with one-cycle register delay, independent of FSM.

Reset
REQ-029 While i_rst=1: FSM IDLE, counter 0, target 0000, all outputs 0 except o_cmd_ready=0 during reset, 1 first cycle after release.
REQ-030 Reset mid-command drops o_lp_wake_req and o_lp_state_req to 0 immediately (asynchronous), no done/err pulse.

Structure
REQ-031 Shared package rdi_pkg holds the 4-bit state encodings enum, FSM state enum, default TIMEOUT_CYCLES.
REQ-032 Timeout counter is sub-module rdi_timeout_cnt (clear, enable, parameterised terminal count, expire flag).
REQ-033 All outputs registered; no combinational path input -> output.

Verification
REQ-034 Accept ACTIVE (0001) from sts 0000, ack 3 cycles after wake_req, sts=0001 5 cycles later -> state_req=0001, wake_req drops, done pulse after ack drops.
REQ-035 Accept 0111 -> err pulse next cycle, wake_req stays 0.
REQ-036 TIMEOUT_CYCLES=16, never ack -> ABORT after 16 cycles in WAIT_ACK, state_req=0000, err pulse once ack low.
REQ-037 In WAIT_STS for L1 (0100), sts=1010 -> ABORT, err pulse, no done.
REQ-038 i_rst pulsed in WAIT_STS -> wake_req and state_req 0 same time step, ready=1 after release.
REQ-039 Target 0001 while sts=0001 -> done next cycle, no wake; clk_req 0->1->0 -> clk_ack follows 1 cycle late.
